// File: rtl/spad_stream_ctrl_pkg.sv
// rtl/spad_stream_ctrl_pkg.sv - shared types and constants for the SPad stream controller
package spad_stream_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_READ  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam int DEF_D_WIDTH = 32;
  localparam int DEF_A_WIDTH = 8;
  localparam int SKID_DEPTH  = 2;

endpackage

// File: rtl/spad_skid_fifo.sv
// rtl/spad_skid_fifo.sv - two-entry skid FIFO absorbing the SPad read latency
module spad_skid_fifo
  import spad_stream_ctrl_pkg::*;
#(
  parameter int WIDTH = 34
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem_q [SKID_DEPTH];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= din;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Head is read straight from storage so it holds steady while stalled.
  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/spad_stream_ctrl.sv
// rtl/spad_stream_ctrl.sv - SPad fill/replay stream controller (option: SPAD_STREAM_CTRL_ZERO_FLAG_EN)
module spad_stream_ctrl
  import spad_stream_ctrl_pkg::*;
#(
  parameter int D_WIDTH = DEF_D_WIDTH,
  parameter int A_WIDTH = DEF_A_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [A_WIDTH:0]   cfg_len,
  input  logic [7:0]         cfg_reps,
  output logic               busy,
  output logic               done,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [D_WIDTH-1:0] in_data,
  output logic               spad_wen,
  output logic [A_WIDTH-1:0] spad_waddr,
  output logic [D_WIDTH-1:0] spad_wdata,
  output logic               spad_ren,
  output logic [A_WIDTH-1:0] spad_raddr,
  input  logic [D_WIDTH-1:0] spad_rdata,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [D_WIDTH-1:0] out_data,
  output logic               out_last
`ifdef SPAD_STREAM_CTRL_ZERO_FLAG_EN
  ,
  output logic               out_zero
`endif
);

`ifdef SPAD_STREAM_CTRL_ZERO_FLAG_EN
  localparam int FW = D_WIDTH + 2;
`else
  localparam int FW = D_WIDTH + 1;
`endif
  localparam logic [A_WIDTH:0] ONE = 1;

  state_t           state_q, state_d;
  logic [A_WIDTH:0] len_q, wcnt_q, rcnt_q;
  logic [7:0]       reps_q, pass_q;
  logic             ren_q, rlast_q, done_q;
  logic [1:0]       fifo_count;
  logic [FW-1:0]    push_word, head_word;
  logic [2:0]       occ_next;
  logic             pop, wr_hs, wr_last, rd_issue, rd_last_word, rd_last_pass;

  always_comb begin
    state_d      = state_q;
    in_ready     = 1'b0;
    wr_hs        = 1'b0;
    rd_issue     = 1'b0;
    out_valid    = (fifo_count != 2'd0);
    pop          = out_valid & out_ready;
    wr_last      = (wcnt_q == len_q - ONE);
    rd_last_word = (rcnt_q == len_q - ONE);
    rd_last_pass = (pass_q == reps_q - 8'd1);
    // Occupancy the buffer would reach if nothing else happened; keeps a slot for every read.
    occ_next     = {1'b0, fifo_count} + {2'b00, ren_q} - {2'b00, pop};

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (cfg_len == '0 || cfg_reps == 8'd0) state_d = ST_DONE;
          else                                   state_d = ST_FILL;
        end
      end
      ST_FILL: begin
        in_ready = 1'b1;
        wr_hs    = in_valid;
        if (wr_hs && wr_last) state_d = ST_READ;
      end
      ST_READ: begin
        rd_issue = (occ_next < 3'd2);
        if (rd_issue && rd_last_word && rd_last_pass) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!out_valid && !ren_q) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      reps_q  <= 8'd0;
      wcnt_q  <= '0;
      rcnt_q  <= '0;
      pass_q  <= 8'd0;
      ren_q   <= 1'b0;
      rlast_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == ST_DONE);
      ren_q   <= rd_issue;
      rlast_q <= rd_issue & rd_last_word;
      if (state_q == ST_IDLE && start) begin
        len_q  <= cfg_len;
        reps_q <= cfg_reps;
        wcnt_q <= '0;
        rcnt_q <= '0;
        pass_q <= 8'd0;
      end
      if (wr_hs) begin
        wcnt_q <= wr_last ? '0 : wcnt_q + ONE;
      end
      if (rd_issue) begin
        if (rd_last_word) begin
          rcnt_q <= '0;
          pass_q <= rd_last_pass ? 8'd0 : pass_q + 8'd1;
        end else begin
          rcnt_q <= rcnt_q + ONE;
        end
      end
    end
  end

`ifdef SPAD_STREAM_CTRL_ZERO_FLAG_EN
  assign push_word = {rlast_q, (spad_rdata == '0), spad_rdata};
  assign out_zero  = head_word[D_WIDTH];
`else
  assign push_word = {rlast_q, spad_rdata};
`endif

  spad_skid_fifo #(
    .WIDTH(FW)
  ) u_skid (
    .clk  (clk),
    .rst  (rst),
    .push (ren_q),
    .pop  (pop),
    .din  (push_word),
    .dout (head_word),
    .count(fifo_count)
  );

  assign busy       = (state_q != ST_IDLE);
  assign done       = done_q;
  assign spad_wen   = wr_hs;
  assign spad_waddr = wcnt_q[A_WIDTH-1:0];
  assign spad_wdata = wr_hs ? in_data : '0;
  assign spad_ren   = rd_issue;
  assign spad_raddr = rcnt_q[A_WIDTH-1:0];
  assign out_data   = head_word[D_WIDTH-1:0];
  assign out_last   = head_word[FW-1];

endmodule

// File: tb/tb_spad_stream_ctrl.sv
// tb/tb_spad_stream_ctrl.sv - self-checking bench for spad_stream_ctrl
module tb_spad_stream_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, in_valid, out_ready;
  logic [8:0]  cfg_len;
  logic [7:0]  cfg_reps;
  logic [31:0] in_data, spad_rdata;
  logic        busy, done, in_ready, spad_wen, spad_ren, out_valid, out_last;
  logic [7:0]  spad_waddr, spad_raddr;
  logic [31:0] spad_wdata, out_data;
`ifdef SPAD_STREAM_CTRL_ZERO_FLAG_EN
  logic        out_zero;
`endif

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] spad_mem [256];

  always #5 clk = ~clk;

  spad_stream_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .cfg_len(cfg_len), .cfg_reps(cfg_reps),
    .busy(busy), .done(done),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .spad_wen(spad_wen), .spad_waddr(spad_waddr), .spad_wdata(spad_wdata),
    .spad_ren(spad_ren), .spad_raddr(spad_raddr), .spad_rdata(spad_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
`ifdef SPAD_STREAM_CTRL_ZERO_FLAG_EN
    , .out_zero(out_zero)
`endif
  );

  always @(posedge clk) begin
    if (spad_wen) spad_mem[spad_waddr] <= spad_wdata;
    if (spad_ren) spad_rdata <= spad_mem[spad_raddr];
  end

  typedef struct packed {
    logic [8:0]        len;
    logic [7:0]        reps;
    logic              stall;
    logic [3:0][31:0]  din;
    logic [3:0]        n_exp;
    logic [7:0][31:0]  exp_data;
    logic [7:0]        exp_last;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic run_vec(input int v);
    vec_t        tv;
    int          k, first_v, last_p;
    logic        hold, pl, bad_wen, bad_stable, got_done;
    logic [31:0] pd;
    tv = vecs[v];
    cfg_len = tv.len; cfg_reps = tv.reps; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < int'(tv.len); i++) begin
      in_valid = 1'b1; in_data = tv.din[i];
      @(negedge clk);
      chk("fill_in_ready", {31'd0, in_ready}, 32'd1);
      chk("fill_busy", {31'd0, busy}, 32'd1);
      chk("fill_wen", {31'd0, spad_wen}, 32'd1);
      chk("fill_waddr", {24'd0, spad_waddr}, i);
      chk("fill_wdata", spad_wdata, tv.din[i]);
      chk("fill_no_ren", {31'd0, spad_ren}, 32'd0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    k = 0; first_v = -1; last_p = -1; hold = 1'b0; pd = '0; pl = 1'b0;
    bad_wen = 1'b0; bad_stable = 1'b0;
    for (int c = 0; c < 200 && k < int'(tv.n_exp); c++) begin
      out_ready = tv.stall ? (c % 2 == 0) : 1'b1;
      @(negedge clk);
      if (c == 0) begin
        chk("read_in_ready", {31'd0, in_ready}, 32'd0);
        chk("first_ren", {31'd0, spad_ren}, 32'd1);
        chk("first_raddr", {24'd0, spad_raddr}, 32'd0);
      end
      if (spad_wen) bad_wen = 1'b1;
      if (hold && (out_data !== pd || out_last !== pl)) bad_stable = 1'b1;
      if (out_valid && first_v < 0) first_v = c;
      if (out_valid && out_ready) begin
        chk("out_data", out_data, tv.exp_data[k]);
        chk("out_last", {31'd0, out_last}, {31'd0, tv.exp_last[k]});
`ifdef SPAD_STREAM_CTRL_ZERO_FLAG_EN
        chk("out_zero", {31'd0, out_zero}, {31'd0, tv.exp_data[k] == 32'd0});
`endif
        last_p = c;
        k++;
      end
      hold = out_valid && !out_ready; pd = out_data; pl = out_last;
      @(posedge clk); #1;
    end
    chk("word_count", k, {28'd0, tv.n_exp});
    chk("first_valid_lat", first_v, 32'd2);
    if (!tv.stall) chk("back_to_back", last_p - first_v, {28'd0, tv.n_exp} - 32'd1);
    chk("no_wen_in_read", {31'd0, bad_wen}, 32'd0);
    chk("stall_stable", {31'd0, bad_stable}, 32'd0);
    out_ready = 1'b1;
    got_done = 1'b0;
    for (int c = 0; c < 30 && !got_done; c++) begin
      @(negedge clk);
      if (out_valid && !got_done) begin
        chk("extra_word", {31'd0, out_valid}, 32'd0);
      end
      if (done) got_done = 1'b1;
      @(posedge clk); #1;
    end
    chk("done_seen", {31'd0, got_done}, 32'd1);
    @(negedge clk);
    chk("done_one_cycle", {31'd0, done}, 32'd0);
    chk("idle_after_done", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // din and exp_data: index 0 is the rightmost element of each concatenation.
    vecs[0] = '{len: 9'd4, reps: 8'd1, stall: 1'b0,
                din: {32'd40, 32'd30, 32'd20, 32'd10}, n_exp: 4'd4,
                exp_data: {32'd0, 32'd0, 32'd0, 32'd0, 32'd40, 32'd30, 32'd20, 32'd10},
                exp_last: 8'b0000_1000};
    vecs[1] = '{len: 9'd3, reps: 8'd2, stall: 1'b0,
                din: {32'd0, 32'd300, 32'd200, 32'd100}, n_exp: 4'd6,
                exp_data: {32'd0, 32'd0, 32'd300, 32'd200, 32'd100, 32'd300, 32'd200, 32'd100},
                exp_last: 8'b0010_0100};
    vecs[2] = '{len: 9'd3, reps: 8'd2, stall: 1'b1,
                din: {32'd0, 32'd300, 32'd200, 32'd100}, n_exp: 4'd6,
                exp_data: {32'd0, 32'd0, 32'd300, 32'd200, 32'd100, 32'd300, 32'd200, 32'd100},
                exp_last: 8'b0010_0100};
    vecs[3] = '{len: 9'd1, reps: 8'd1, stall: 1'b0,
                din: {32'd0, 32'd0, 32'd0, 32'd7}, n_exp: 4'd1,
                exp_data: {32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd7},
                exp_last: 8'b0000_0001};
    vecs[4] = '{len: 9'd2, reps: 8'd3, stall: 1'b1,
                din: {32'd0, 32'd0, 32'd5, 32'd0}, n_exp: 4'd6,
                exp_data: {32'd0, 32'd0, 32'd5, 32'd0, 32'd5, 32'd0, 32'd5, 32'd0},
                exp_last: 8'b0010_1010};

    rst = 1'b1; start = 1'b1; cfg_len = 9'd4; cfg_reps = 8'd1;
    in_valid = 1'b0; in_data = 32'hdead_beef; out_ready = 1'b0;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_wen", {31'd0, spad_wen}, 32'd0);
    chk("rst_ren", {31'd0, spad_ren}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_last", {31'd0, out_last}, 32'd0);
    chk("rst_waddr", {24'd0, spad_waddr}, 32'd0);
    chk("rst_raddr", {24'd0, spad_raddr}, 32'd0);
    chk("rst_wdata", spad_wdata, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("start_in_rst_ignored", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;

    for (int v = 0; v < 5; v++) run_vec(v);

    // Zero-length and zero-rep starts: done two cycles after start, no SPad access.
    for (int z = 0; z < 2; z++) begin
      logic acc;
      acc = 1'b0;
      cfg_len = (z == 0) ? 9'd0 : 9'd2;
      cfg_reps = (z == 0) ? 8'd3 : 8'd0;
      start = 1'b1;
      @(negedge clk);
      if (spad_wen || spad_ren) acc = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      chk("zero_t1_done", {31'd0, done}, 32'd0);
      chk("zero_t1_busy", {31'd0, busy}, 32'd1);
      if (spad_wen || spad_ren) acc = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      chk("zero_t2_done", {31'd0, done}, 32'd1);
      if (spad_wen || spad_ren) acc = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      chk("zero_t3_done", {31'd0, done}, 32'd0);
      chk("zero_restart_ignored", {31'd0, busy}, 32'd0);
      if (spad_wen || spad_ren) acc = 1'b1;
      chk("zero_no_access", {31'd0, acc}, 32'd0);
      @(posedge clk); #1;
    end

    // Abort in the middle of READ, then a fresh single-word operation.
    cfg_len = 9'd3; cfg_reps = 8'd2; start = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 32'd100 * (i + 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    chk("pre_abort_valid", {31'd0, out_valid}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_ren", {31'd0, spad_ren}, 32'd0);
    @(posedge clk); #1;
    run_vec(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/spad_stream_ctrl.md
# spad_stream_ctrl

Initiator-side controller for the PE scratchpad (SPad). It accepts a burst of operand words on a valid/ready input stream, writes them into the SPad at consecutive addresses, then reads them back as one or more sequential passes onto a valid/ready output stream toward the PE MAC. It sits between the PE input FIFO and the MAC datapath. It drives the SPad write and read ports directly and absorbs the SPad's one-cycle read latency with a two-entry skid buffer.

## Interface
- D_WIDTH, 32, SPad word width
- A_WIDTH, 8, SPad address width; SPad depth is 2^A_WIDTH
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous reset, active-high
- start  in  1  begin an operation; sampled only in IDLE
- cfg_len  in  A_WIDTH+1  words per pass, 0..2^A_WIDTH; latched on start
- cfg_reps  in  8  number of read passes, 0..255; latched on start
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when the operation completes
- in_valid / in_ready / in_data  in / out / D_WIDTH  fill stream
- spad_wen  out  1  SPad write enable
- spad_waddr  out  A_WIDTH  SPad write address
- spad_wdata  out  D_WIDTH  SPad write data
- spad_ren  out  1  SPad read enable
- spad_raddr  out  A_WIDTH  SPad read address
- spad_rdata  in  D_WIDTH  SPad read data; valid the cycle after spad_ren
- out_valid / out_ready / out_data  out / in / D_WIDTH  replay stream
- out_last  out  1  qualifies the final word of each pass

## Operation
- FSM states: IDLE, FILL, READ, DRAIN, DONE.
- IDLE: in_ready=0. On start, latch cfg_len and cfg_reps. If either is 0, go to DONE. Otherwise go to FILL.
- FILL: in_ready=1. On each handshake, spad_wen=1 combinationally, with spad_waddr=wcnt and spad_wdata=in_data. wcnt increments from 0.
  - After cfg_len handshakes, go to READ and set in_ready=0 the same cycle.
- READ: assert spad_ren with spad_raddr=rcnt when occupancy + inflight − pop < 2.
  - pop = out_valid & out_ready; inflight = spad_ren of the previous cycle.
  - rcnt runs 0..cfg_len−1, then wraps to 0 and increments the pass counter.
  - After the last read of pass cfg_reps, go to DRAIN.
- The read word is pushed into the skid buffer the cycle after spad_ren. A tag bit carries out_last.
- out_valid = buffer not empty. out_data and out_last are taken from the buffer head.
- DRAIN: no new reads. Go to DONE when the buffer is empty and nothing is in flight.
- DONE: done=1 for one cycle, then IDLE.
- start outside IDLE is ignored. The controller never writes during READ/DRAIN and never reads during FILL.
- cfg_len = 2^A_WIDTH is legal. Addresses wrap naturally at the top.

## Timing
- Reset: busy, done, in_ready, spad_wen, spad_ren, out_valid and out_last are 0. spad_waddr, spad_raddr, spad_wdata and out_data are 0. Counters are 0, the buffer is empty, and state is IDLE.
- rst mid-operation aborts on the next edge. In-flight read data is discarded. SPad contents are untouched.
- start at cycle t gives in_ready=1 at t+1.
- The READ state entered at cycle r gives the first spad_ren at r. The first out_valid is at r+2.
- With out_ready held high, the controller sustains one output word per cycle.
- out_data and out_last stay stable while out_valid=1 and out_ready=0.
- A zero-length or zero-rep start gives done at t+2, with no SPad access.

## Configuration
- Macro: SPAD_STREAM_CTRL_ZERO_FLAG_EN.
- When defined: the port out_zero (out, 1) is added. It is stored in the buffer with each word and is 1 when the word equals 0. This gates the MAC for zero skipping. Its reset value is 0.
- When undefined: the port and buffer bit are absent, and behaviour is otherwise identical.

## Structure
- Package spad_stream_ctrl_pkg holds:
  - the FSM state enum (3-bit encoding);
  - default D_WIDTH and A_WIDTH;
  - the skid depth constant (2).
- Sub-module spad_skid_fifo: a 2-entry FIFO with push/pop/count, parameterised width (data + last [+ zero]), and synchronous active-high reset.

## Test plan
- Reset: hold rst for 2 cycles → all outputs 0 and busy=0. start during rst is ignored.
- cfg_len=4, cfg_reps=1, feed 10,20,30,40 → spad_wen at addresses 0..3 with those data; output 10,20,30,40; out_last only on 40; one-cycle done.
- cfg_len=3, cfg_reps=2, data 100,200,300, out_ready=1 → six back-to-back words 100,200,300,100,200,300; out_last on words 3 and 6.
- Same as above but out_ready toggles 1,0,1,0 → no word lost or duplicated; out_data stable during stalls; buffer never exceeds 2.
- cfg_len=0 → done at t+2; spad_wen and spad_ren never assert; a second start in DONE is ignored.
- rst asserted mid-READ → IDLE with out_valid=0 next cycle. A fresh start with cfg_len=1 (data 7) yields a single word 7 with out_last. With the macro defined, a word 0 gives out_zero=1.
